// File: rtl/ks28_add_arbiter.sv
// Round-robin arbiter sharing one pipelined adder between NREQ requesters.
// A tag pipeline matched to adder latency routes each sum back to its owner.
module ks28_add_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 28,
    parameter int LAT     = 3,
    parameter int MAX_OUT = 2,
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [NREQ*W-1:0] REQ_A,
    input  logic [NREQ*W-1:0] REQ_B,
    input  logic [NREQ-1:0]   REQ_CIN,
    output logic [W-1:0]      ADD_A,
    output logic [W-1:0]      ADD_B,
    output logic              ADD_CIN,
    input  logic [W-1:0]      ADD_SUM,
    input  logic              ADD_COUT,
    output logic              RSP_VALID,
    output logic [IW-1:0]     RSP_ID,
    output logic [W-1:0]      RSP_SUM,
    output logic              RSP_COUT,
    output logic              BUSY
);

    localparam int CW = $clog2(MAX_OUT + 1);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] out_q [NREQ];
    logic [CW-1:0] out_d [NREQ];
    logic [LAT:0]  tv_q;
    logic [IW-1:0] tid_q [LAT+1];
    logic          init_q;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          cin_q, cin_d;

    logic            rsp_raw;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gid;
    logic            found;
    int              idx;

    assign rsp_raw = tv_q[LAT];

    // A response retiring this cycle frees its slot for a same-cycle grant.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = REQ_VALID[i] &&
                ((out_q[i] - CW'(rsp_raw && (int'(tid_q[LAT]) == i)))
                 < CW'(MAX_OUT));
        end
    end

    always_comb begin
        gnt   = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        if (ENABLE && !RST && !init_q) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(ptr_q) + k) % NREQ;
                if (!found && elig[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gid      = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        a_d   = '0;
        b_d   = '0;
        cin_d = 1'b0;
        ptr_d = ptr_q;
        if (found) begin
            a_d   = REQ_A[gid*W +: W];
            b_d   = REQ_B[gid*W +: W];
            cin_d = REQ_CIN[gid];
            ptr_d = (int'(gid) == NREQ - 1) ? '0 : gid + IW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            out_d[i] = out_q[i]
                + CW'(found && (int'(gid) == i))
                - CW'(rsp_raw && (int'(tid_q[LAT]) == i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            init_q <= 1'b1;
            ptr_q  <= '0;
            tv_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            for (int i = 0; i < NREQ; i++) out_q[i] <= '0;
            for (int s = 0; s <= LAT; s++) tid_q[s] <= '0;
        end else begin
            init_q   <= 1'b0;
            ptr_q    <= ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            tv_q     <= {tv_q[LAT-1:0], found};
            tid_q[0] <= gid;
            for (int s = 1; s <= LAT; s++) tid_q[s] <= tid_q[s-1];
            for (int i = 0; i < NREQ; i++) out_q[i] <= out_d[i];
        end
    end

    assign REQ_READY = gnt;
    assign ADD_A     = a_q;
    assign ADD_B     = b_q;
    assign ADD_CIN   = cin_q;
    assign RSP_VALID = rsp_raw & ~RST;
    assign RSP_ID    = RSP_VALID ? tid_q[LAT] : '0;
    assign RSP_SUM   = RSP_VALID ? ADD_SUM : '0;
    assign RSP_COUT  = RSP_VALID & ADD_COUT;
    assign BUSY      = (|tv_q) & ~RST;

endmodule

// File: tb/tb_ks28_add_arbiter.sv
// Bench for ks28_add_arbiter: pipelined adder stand-in plus a
// queue-based model of grants, outstanding limits and responses.
module tb_ks28_add_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 28;
    localparam int LAT     = 3;
    localparam int MAX_OUT = 2;
    localparam int IW      = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [W-1:0]      add_a, add_b, add_sum;
    logic              add_cin, add_cout;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              busy;

    always #5 clk = ~clk;

    ks28_add_arbiter #(
        .NREQ(NREQ), .W(W), .LAT(LAT), .MAX_OUT(MAX_OUT)
    ) dut (
        .CLK(clk), .RST(rst), .ENABLE(en),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_A(req_a), .REQ_B(req_b), .REQ_CIN(req_cin),
        .ADD_A(add_a), .ADD_B(add_b), .ADD_CIN(add_cin),
        .ADD_SUM(add_sum), .ADD_COUT(add_cout),
        .RSP_VALID(rsp_valid), .RSP_ID(rsp_id),
        .RSP_SUM(rsp_sum), .RSP_COUT(rsp_cout), .BUSY(busy)
    );

    // Adder stand-in: LAT register stages of plain addition.
    logic [W:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
        for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign add_sum  = pipe[LAT-1][W-1:0];
    assign add_cout = pipe[LAT-1][W];

    typedef struct {
        int         due;
        int         id;
        logic [W:0] res;
    } rsp_t;

    rsp_t       q[$];
    int         cyc;
    int         ptr_m;
    bit         init_m;
    logic [W-1:0] ea, eb;
    logic       ec;
    int         checks;
    int         failures;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h",
                     tag, cyc, obs, exp);
        end
    endtask

    function automatic int inflight(int id);
        int n = 0;
        foreach (q[j]) if (q[j].id == id && q[j].due != cyc) n++;
        return n;
    endfunction

    task automatic cycle();
        int         g;
        int         idx;
        logic [W:0] r;
        bit         due_now;
        @(negedge clk);
        g = -1;
        if (!rst && en && !init_m) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr_m + k) % NREQ;
                if (g < 0 && req_valid[idx] && inflight(idx) < MAX_OUT)
                    g = idx;
            end
        end
        due_now = !rst && q.size() > 0 && q[0].due == cyc;
        chk("ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("rsp_valid", 32'(rsp_valid), 32'(due_now));
        if (due_now) begin
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_sum", 32'(rsp_sum), 32'(q[0].res[W-1:0]));
            chk("rsp_cout", 32'(rsp_cout), 32'(q[0].res[W]));
        end else begin
            chk("rsp_sum_idle", 32'(rsp_sum), 32'd0);
        end
        chk("busy", 32'(busy), 32'(!rst && q.size() > 0));
        chk("add_a", 32'(add_a), 32'(ea));
        chk("add_b", 32'(add_b), 32'(eb));
        chk("add_cin", 32'(add_cin), 32'(ec));
        @(posedge clk);
        if (rst) begin
            q.delete();
            ptr_m  = 0;
            init_m = 1'b1;
            ea = '0; eb = '0; ec = 1'b0;
        end else begin
            init_m = 1'b0;
            if (due_now) void'(q.pop_front());
            if (g >= 0) begin
                ea = req_a[g*W +: W];
                eb = req_b[g*W +: W];
                ec = req_cin[g];
                r  = {1'b0, ea} + {1'b0, eb} + (W+1)'(ec);
                q.push_back('{due: cyc + 1 + LAT, id: g, res: r});
                ptr_m = (g + 1) % NREQ;
            end else begin
                ea = '0; eb = '0; ec = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
            req_cin[i]      = 1'($urandom);
        end
    endtask

    task automatic run(int n, logic [NREQ-1:0] mask);
        for (int i = 0; i < n; i++) begin
            req_valid = mask;
            rand_ops();
            cycle();
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; ptr_m = 0; init_m = 1'b1;
        ea = '0; eb = '0; ec = 1'b0;
        rst = 1'b1; en = 1'b1; req_valid = '0;
        req_a = '0; req_b = '0; req_cin = '0;
        @(posedge clk);
        #1;

        // reset held two cycles, then idle
        cycle();
        cycle();
        rst = 1'b0;
        run(10, '0);

        // single op from requester 2
        req_valid = 4'b0100;
        req_a = '0; req_b = '0; req_cin = '0;
        req_a[2*W +: W] = W'(1);
        req_b[2*W +: W] = W'(1);
        req_cin[2]      = 1'b1;
        cycle();
        req_valid = '0;
        for (int i = 0; i < LAT + 3; i++) cycle();

        // all requesters valid continuously
        run(24, 4'b1111);
        run(LAT + 2, '0);

        // outstanding limit with carry-out
        req_valid = 4'b0010;
        req_a[1*W +: W] = {W{1'b1}};
        req_b[1*W +: W] = W'(1);
        req_cin[1]      = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        req_valid = '0;
        for (int i = 0; i < LAT + 2; i++) cycle();

        // enable drain with ops in flight
        run(3, 4'b1111);
        en = 1'b0;
        run(LAT + 4, 4'b1111);
        en = 1'b1;
        run(6, 4'b1111);
        run(LAT + 2, '0);

        // reset with ops in flight
        run(2, 4'b0011);
        rst = 1'b1;
        run(1, 4'b0011);
        rst = 1'b0;
        run(10, 4'b0001);
        run(LAT + 2, '0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            en  = ($urandom_range(7) != 0);
            rst = ($urandom_range(63) == 0);
            run(1, NREQ'($urandom));
        end
        rst = 1'b0;
        en  = 1'b1;
        run(LAT + 3, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
